// File: rtl/simple_processor_pkg.sv
// simple_processor_pkg: shared widths, ALU function codes and instruction layout
package simple_processor_pkg;
    localparam int DATA_WIDTH  = 8;
    localparam int NUM_REGS    = 16;
    localparam int REG_ADDR_W  = $clog2(NUM_REGS);
    localparam int INSTR_WIDTH = 3 + 3 * REG_ADDR_W;
    typedef enum logic [2:0] {
        FUNC_AND = 3'd0,
        FUNC_OR  = 3'd1,
        FUNC_XOR = 3'd2,
        FUNC_NOT = 3'd3
    } func_t;
    typedef struct packed {
        func_t                 func;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
    } instr_t;
endpackage

// File: rtl/reg_file.sv
// reg_file: two async read ports, one sync write port with write-through bypass
module reg_file
    import simple_processor_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end
    always_comb begin
        rd_data_a = (wr_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
        rd_data_b = (wr_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
    end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: decode, hazard-checked operand read and registered issue to the ALU
module operand_fetch
    import simple_processor_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   arst_ni,
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic                   instr_valid_i,
    output logic                   instr_ready_o,
    input  logic                   wb_en_i,
    input  logic [REG_ADDR_W-1:0]  wb_addr_i,
    input  logic [DATA_WIDTH-1:0]  wb_data_i,
    output logic                   ex_valid_o,
    input  logic                   ex_ready_i,
    output logic [DATA_WIDTH-1:0]  rs1_data_o,
    output logic [DATA_WIDTH-1:0]  rs2_data_o,
    output func_t                  func_o,
    output logic [REG_ADDR_W-1:0]  rd_addr_o,
    output logic                   illegal_o
);
    instr_t                ins;
    logic [NUM_REGS-1:0]   pend, pend_nxt;
    logic [DATA_WIDTH-1:0] rf_a, rf_b;
    logic                  is_not, legal, blk1, blk2, blkd, slot_free, accept, issue;
    assign ins = instr_t'(instr_i);
    reg_file u_reg_file (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .wr_en     (wb_en_i),
        .wr_addr   (wb_addr_i),
        .wr_data   (wb_data_i),
        .rd_addr_a (ins.rs1),
        .rd_addr_b (ins.rs2),
        .rd_data_a (rf_a),
        .rd_data_b (rf_b)
    );
    // Sources may be released by a same-cycle writeback; rd never is, so WAW always stalls.
    always_comb begin
        is_not        = ins.func == FUNC_NOT;
        legal         = ~ins.func[2];
        blk1          = pend[ins.rs1] & ~(wb_en_i && wb_addr_i == ins.rs1);
        blk2          = ~is_not & pend[ins.rs2] & ~(wb_en_i && wb_addr_i == ins.rs2);
        blkd          = pend[ins.rd];
        slot_free     = ~ex_valid_o | ex_ready_i;
        instr_ready_o = slot_free & ~(blk1 | blk2 | blkd);
        accept        = instr_valid_i & instr_ready_o;
        issue         = accept & legal;
    end
    always_comb begin
        pend_nxt = pend;
        if (wb_en_i) pend_nxt[wb_addr_i] = 1'b0;
        if (issue) pend_nxt[ins.rd] = 1'b1;
    end
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            pend       <= '0;
            ex_valid_o <= 1'b0;
            illegal_o  <= 1'b0;
            rs1_data_o <= '0;
            rs2_data_o <= '0;
            func_o     <= FUNC_AND;
            rd_addr_o  <= '0;
        end else begin
            pend      <= pend_nxt;
            illegal_o <= accept & ~legal;
            if (issue) begin
                ex_valid_o <= 1'b1;
                rs1_data_o <= rf_a;
                rs2_data_o <= is_not ? '0 : rf_b;
                func_o     <= ins.func;
                rd_addr_o  <= ins.rd;
            end else if (ex_ready_i) begin
                ex_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: randomized scoreboard bench against a behavioural model of operand_fetch
module tb_operand_fetch;
    import simple_processor_pkg::*;
    typedef struct {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [2:0]            f;
        logic [REG_ADDR_W-1:0] rd;
    } exp_t;
    logic                   clk_i = 1'b0;
    logic                   arst_ni;
    logic [INSTR_WIDTH-1:0] instr_i;
    logic                   instr_valid_i;
    logic                   instr_ready_o;
    logic                   wb_en_i;
    logic [REG_ADDR_W-1:0]  wb_addr_i;
    logic [DATA_WIDTH-1:0]  wb_data_i;
    logic                   ex_valid_o;
    logic                   ex_ready_i;
    logic [DATA_WIDTH-1:0]  rs1_data_o;
    logic [DATA_WIDTH-1:0]  rs2_data_o;
    func_t                  func_o;
    logic [REG_ADDR_W-1:0]  rd_addr_o;
    logic                   illegal_o;
    int n_chk = 0;
    int n_fail = 0;
    exp_t q[$];
    logic [DATA_WIDTH-1:0] m_regs [NUM_REGS];
    bit                    m_pend [NUM_REGS];
    bit                    exp_ill = 0;
    operand_fetch dut (
        .clk_i         (clk_i),
        .arst_ni       (arst_ni),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .wb_en_i       (wb_en_i),
        .wb_addr_i     (wb_addr_i),
        .wb_data_i     (wb_data_i),
        .ex_valid_o    (ex_valid_o),
        .ex_ready_i    (ex_ready_i),
        .rs1_data_o    (rs1_data_o),
        .rs2_data_o    (rs2_data_o),
        .func_o        (func_o),
        .rd_addr_o     (rd_addr_o),
        .illegal_o     (illegal_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask
    function automatic logic [INSTR_WIDTH-1:0] mk(input int f, input int rd, input int rs1, input int rs2);
        logic [2:0] fv = 3'(f);
        return {fv, REG_ADDR_W'(rd), REG_ADDR_W'(rs1), REG_ADDR_W'(rs2)};
    endfunction
    task automatic model_clear();
        q.delete();
        exp_ill = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 0;
        end
    endtask
    // One clock cycle: drive, check ready against the model, then advance the model past the edge.
    task automatic step(input bit v, input logic [INSTR_WIDTH-1:0] ins, input bit we,
                        input int wa, input logic [DATA_WIDTH-1:0] wd, input bit er, output bit acc);
        int f, rd, s1, s2;
        bit hz;
        exp_t e;
        f  = int'(ins[INSTR_WIDTH-1 -: 3]);
        rd = int'(ins[3*REG_ADDR_W-1 -: REG_ADDR_W]);
        s1 = int'(ins[2*REG_ADDR_W-1 -: REG_ADDR_W]);
        s2 = int'(ins[REG_ADDR_W-1:0]);
        @(negedge clk_i);
        instr_valid_i = v;
        instr_i       = ins;
        wb_en_i       = we;
        wb_addr_i     = REG_ADDR_W'(wa);
        wb_data_i     = wd;
        ex_ready_i    = er;
        #1;
        hz = (m_pend[s1] && !(we && wa == s1)) || (f != 3 && m_pend[s2] && !(we && wa == s2)) || m_pend[rd];
        chk("instr_ready", 32'(instr_ready_o), 32'((q.size() == 0 || er) && !hz));
        acc  = v && (q.size() == 0 || er) && !hz;
        e.a  = (we && wa == s1) ? wd : m_regs[s1];
        e.b  = (f == 3) ? '0 : (we && wa == s2) ? wd : m_regs[s2];
        e.f  = 3'(f);
        e.rd = REG_ADDR_W'(rd);
        @(posedge clk_i);
        #1;
        if (we) begin
            m_regs[wa] = wd;
            m_pend[wa] = 0;
        end
        if (acc && f < 4) begin
            q.push_back(e);
            m_pend[rd] = 1;
        end
        exp_ill = acc && f >= 4;
    endtask
    // Monitor: the queue holds whatever the output slot should contain.
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            chk("ex_valid", 32'(ex_valid_o), 32'(q.size() != 0));
            chk("illegal", 32'(illegal_o), 32'(exp_ill));
            if (ex_valid_o && q.size() != 0) begin
                chk("rs1_data", 32'(rs1_data_o), 32'(q[0].a));
                chk("rs2_data", 32'(rs2_data_o), 32'(q[0].b));
                chk("func", 32'(func_o), 32'(q[0].f));
                chk("rd_addr", 32'(rd_addr_o), 32'(q[0].rd));
                if (ex_ready_i) void'(q.pop_front());
            end
        end
    end
    task automatic chk_zero_outputs();
        chk("rst_ex_valid", 32'(ex_valid_o), 0);
        chk("rst_illegal", 32'(illegal_o), 0);
        chk("rst_rs1", 32'(rs1_data_o), 0);
        chk("rst_rs2", 32'(rs2_data_o), 0);
        chk("rst_func", 32'(func_o), 0);
        chk("rst_rd", 32'(rd_addr_o), 0);
    endtask
    initial begin
        bit acc, cur_v;
        logic [INSTR_WIDTH-1:0] cur;
        int wa;
        arst_ni = 1'b0;
        instr_valid_i = 0; instr_i = '0; wb_en_i = 0; wb_addr_i = '0; wb_data_i = '0; ex_ready_i = 0;
        model_clear();
        #1;
        chk_zero_outputs();
        #12;
        arst_ni = 1'b1;
        step(0, '0, 1, 3, 8'hA5, 1, acc);
        step(0, '0, 1, 4, 8'h0F, 1, acc);
        step(1, mk(2, 5, 3, 4), 0, 0, 0, 1, acc);
        chk("xor_acc", 32'(acc), 1);
        step(1, mk(1, 11, 5, 3), 0, 0, 0, 1, acc);
        chk("raw_stall0", 32'(acc), 0);
        step(1, mk(1, 11, 5, 3), 0, 0, 0, 1, acc);
        chk("raw_stall1", 32'(acc), 0);
        step(1, mk(1, 11, 5, 3), 1, 5, 8'h05, 1, acc);
        chk("raw_bypass_acc", 32'(acc), 1);
        step(1, mk(0, 8, 1, 2), 1, 11, 8'h33, 0, acc);
        for (int i = 0; i < 3; i++) begin
            step(1, mk(1, 9, 3, 4), 0, 0, 0, 0, acc);
            chk("bp_stall", 32'(acc), 0);
        end
        step(1, mk(1, 9, 3, 4), 0, 0, 0, 1, acc);
        chk("bp_b2b", 32'(acc), 1);
        step(1, mk(0, 7, 3, 4), 1, 8, 8'h11, 1, acc);
        step(1, mk(3, 2, 1, 7), 1, 9, 8'h22, 1, acc);
        chk("not_nostall", 32'(acc), 1);
        step(1, mk(6, 10, 0, 0), 1, 7, 8'h44, 1, acc);
        chk("illegal_acc", 32'(acc), 1);
        step(0, '0, 0, 0, 0, 1, acc);
        step(0, '0, 1, 2, 8'h5A, 1, acc);
        step(1, mk(0, 5, 3, 4), 0, 0, 0, 0, acc);
        step(1, mk(1, 12, 5, 3), 0, 0, 0, 0, acc);
        chk("pre_rst_stall", 32'(acc), 0);
        @(negedge clk_i);
        #3;
        arst_ni = 1'b0;
        instr_valid_i = 0;
        wb_en_i = 0;
        #1;
        chk_zero_outputs();
        model_clear();
        @(negedge clk_i);
        #4;
        arst_ni = 1'b1;
        step(1, mk(1, 12, 5, 3), 0, 0, 0, 1, acc);
        chk("post_rst_acc", 32'(acc), 1);
        cur_v = 0;
        cur = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!cur_v) begin
                cur_v = $urandom_range(0, 3) != 0;
                cur = mk(($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3),
                         $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
            end
            wa = $urandom_range(0, 15);
            if ($urandom_range(0, 2) != 0)
                for (int k = 0; k < NUM_REGS; k++)
                    if (m_pend[(wa + k) % NUM_REGS]) begin
                        wa = (wa + k) % NUM_REGS;
                        break;
                    end
            step(cur_v, cur, $urandom_range(0, 2) != 0, wa, 8'($urandom), $urandom_range(0, 3) != 0, acc);
            if (acc) cur_v = 0;
        end
        step(0, '0, 0, 0, 0, 1, acc);
        step(0, '0, 0, 0, 0, 1, acc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
